// File: rtl/pcie_flow_ctrl_rx_init.sv
// rtl/pcie_flow_ctrl_rx_init.sv - receive-side DLLP framing, CRC check and VC0 InitFC credit capture

module pcie_datalink_crc (
  input  logic [31:0] data,
  input  logic        complement,
  output logic [15:0] crc
);
  logic [15:0] lfsr;
  logic        fb;

  // Bytes 0..3, each LSB first, poly 0x100B seeded with all-ones; result is
  // bit-reversed so tdata[0] carries lfsr bit 15, as on the wire.
  always_comb begin
    lfsr = 16'hFFFF;
    fb   = 1'b0;
    crc  = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      fb   = lfsr[15] ^ data[i];
      lfsr = {lfsr[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    if (complement) lfsr = ~lfsr;
    for (int j = 0; j < 16; j++) crc[j] = lfsr[15-j];
  end
endmodule

module pcie_flow_ctrl_rx_init #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int USER_WIDTH    = 3,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fc_init_en_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep_i,
  input  logic                     s_axis_tvalid_i,
  input  logic                     s_axis_tlast_i,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
  output logic                     s_axis_tready_o,
  output logic                     fc1_values_stored_o,
  output logic                     fc2_values_stored_o,
  output logic [7:0]               p_hdr_fc_o,
  output logic [7:0]               np_hdr_fc_o,
  output logic [7:0]               cpl_hdr_fc_o,
  output logic [11:0]              p_data_fc_o,
  output logic [11:0]              np_data_fc_o,
  output logic [11:0]              cpl_data_fc_o,
  output logic                     credits_valid_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);
  typedef enum logic [1:0] {RX_BODY, RX_CRC, RX_DROP} rx_state_t;
  typedef enum logic [1:0] {INIT_FC1, INIT_FC2, INIT_DONE} init_state_t;

  rx_state_t   rx_state, rx_next;
  init_state_t init_state, init_next;

  logic        tready_q;
  logic [31:0] body_q;
  logic        beat_ok, body_load, err_inc, frame_good;
  logic [15:0] crc_calc;
  logic        crc_match, keep_ok;

  logic [7:0]  dllp_type;
  logic [3:0]  type_hi;
  logic [2:0]  sel_onehot;
  logic        is_fc1, is_fc2, is_upd;
  logic [7:0]  hdr_new;
  logic [11:0] data_new;

  logic [2:0]  seen_q, seen_next;
  logic        fc1_q, fc1_next, fc2_q, fc2_next;
  logic [2:0]  cred_we;
  logic        cred_valid_q;

  logic [7:0]  p_hdr_q, np_hdr_q, cpl_hdr_q;
  logic [11:0] p_data_q, np_data_q, cpl_data_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tuser_i, s_axis_tkeep_i[KEEP_WIDTH-1:2]};

  assign beat_ok = s_axis_tvalid_i & tready_q;

  pcie_datalink_crc u_crc (
    .data       (body_q),
    .complement (1'b1),
    .crc        (crc_calc)
  );

  assign crc_match = (s_axis_tdata_i[15:0] == crc_calc);
  assign keep_ok   = (s_axis_tkeep_i[1:0] == 2'b11);

  always_comb begin
    rx_next    = rx_state;
    body_load  = 1'b0;
    err_inc    = 1'b0;
    frame_good = 1'b0;
    if (beat_ok) begin
      case (rx_state)
        RX_BODY: begin
          body_load = 1'b1;
          if (s_axis_tlast_i) err_inc = 1'b1;
          else                rx_next = RX_CRC;
        end
        RX_CRC: begin
          if (!s_axis_tlast_i) begin
            err_inc = 1'b1;
            rx_next = RX_DROP;
          end else begin
            rx_next = RX_BODY;
            if (crc_match && keep_ok) frame_good = 1'b1;
            else                      err_inc    = 1'b1;
          end
        end
        RX_DROP: if (s_axis_tlast_i) rx_next = RX_BODY;
        default: rx_next = RX_BODY;
      endcase
    end
  end

  // Type byte: high nibble selects DLLP kind, bits [5:4] the credit type,
  // bit 3 must be clear and the VC bits [2:0] are don't-care.
  assign dllp_type  = body_q[7:0];
  assign type_hi    = dllp_type[7:4];
  assign sel_onehot = 3'(3'b001 << dllp_type[5:4]);
  assign is_fc1 = frame_good && !dllp_type[3] &&
                  (type_hi == 4'h4 || type_hi == 4'h5 || type_hi == 4'h6);
  assign is_fc2 = frame_good && !dllp_type[3] &&
                  (type_hi == 4'hC || type_hi == 4'hD || type_hi == 4'hE);
  assign is_upd = frame_good && !dllp_type[3] &&
                  (type_hi == 4'h8 || type_hi == 4'h9 || type_hi == 4'hA);
  assign hdr_new  = {body_q[13:8], body_q[23:22]};
  assign data_new = {body_q[19:16], body_q[31:24]};

  always_comb begin
    init_next = init_state;
    seen_next = seen_q;
    fc1_next  = fc1_q;
    fc2_next  = fc2_q;
    cred_we   = 3'b000;
    case (init_state)
      INIT_FC1: begin
        if (is_fc1) begin
          cred_we   = sel_onehot;
          seen_next = seen_q | sel_onehot;
          if (&seen_next) begin
            init_next = INIT_FC2;
            fc1_next  = 1'b1;
          end
        end
      end
      INIT_FC2: begin
        if (is_fc2 || is_upd) begin
          init_next = INIT_DONE;
          fc2_next  = 1'b1;
        end
      end
      INIT_DONE: init_next = INIT_DONE;
      default:   init_next = INIT_FC1;
    endcase
    // Leaving DL_Init overrides any decode landing in the same cycle.
    if (!fc_init_en_i) begin
      init_next = INIT_FC1;
      seen_next = 3'b000;
      fc1_next  = 1'b0;
      fc2_next  = 1'b0;
      cred_we   = 3'b000;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tready_q     <= 1'b0;
      rx_state     <= RX_BODY;
      body_q       <= 32'h0;
      init_state   <= INIT_FC1;
      seen_q       <= 3'b000;
      fc1_q        <= 1'b0;
      fc2_q        <= 1'b0;
      cred_valid_q <= 1'b0;
      p_hdr_q      <= 8'h0;
      np_hdr_q     <= 8'h0;
      cpl_hdr_q    <= 8'h0;
      p_data_q     <= 12'h0;
      np_data_q    <= 12'h0;
      cpl_data_q   <= 12'h0;
      err_q        <= '0;
    end else begin
      tready_q     <= 1'b1;
      rx_state     <= rx_next;
      init_state   <= init_next;
      seen_q       <= seen_next;
      fc1_q        <= fc1_next;
      fc2_q        <= fc2_next;
      cred_valid_q <= |cred_we;
      if (body_load) body_q <= s_axis_tdata_i[31:0];
      if (cred_we[0]) begin
        p_hdr_q  <= hdr_new;
        p_data_q <= data_new;
      end
      if (cred_we[1]) begin
        np_hdr_q  <= hdr_new;
        np_data_q <= data_new;
      end
      if (cred_we[2]) begin
        cpl_hdr_q  <= hdr_new;
        cpl_data_q <= data_new;
      end
      if (err_inc && !(&err_q)) err_q <= err_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign s_axis_tready_o     = tready_q;
  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign p_hdr_fc_o          = p_hdr_q;
  assign np_hdr_fc_o         = np_hdr_q;
  assign cpl_hdr_fc_o        = cpl_hdr_q;
  assign p_data_fc_o         = p_data_q;
  assign np_data_fc_o        = np_data_q;
  assign cpl_data_fc_o       = cpl_data_q;
  assign credits_valid_o     = cred_valid_q;
  assign err_count_o         = err_q;
endmodule

// File: tb/tb_pcie_flow_ctrl_rx_init.sv
// tb/tb_pcie_flow_ctrl_rx_init.sv - scoreboard bench for pcie_flow_ctrl_rx_init

module tb_pcie_flow_ctrl_rx_init;
  logic        clk = 1'b0;
  logic        rst;
  logic        fc_en;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [2:0]  tuser;
  logic        tready;
  logic        fc1, fc2, cv;
  logic [7:0]  ph, nph, cph;
  logic [11:0] pd, npd, cd;
  logic [7:0]  err;

  typedef struct packed {
    logic [7:0]  ph, nph, cph;
    logic [11:0] pd, npd, cd;
    logic        fc1, fc2;
    logic [7:0]  err;
  } snap_t;

  snap_t exp_s;
  snap_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;

  always #5 clk = ~clk;

  pcie_flow_ctrl_rx_init dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .fc_init_en_i        (fc_en),
    .s_axis_tdata_i      (tdata),
    .s_axis_tkeep_i      (tkeep),
    .s_axis_tvalid_i     (tvalid),
    .s_axis_tlast_i      (tlast),
    .s_axis_tuser_i      (tuser),
    .s_axis_tready_o     (tready),
    .fc1_values_stored_o (fc1),
    .fc2_values_stored_o (fc2),
    .p_hdr_fc_o          (ph),
    .np_hdr_fc_o         (nph),
    .cpl_hdr_fc_o        (cph),
    .p_data_fc_o         (pd),
    .np_data_fc_o        (npd),
    .cpl_data_fc_o       (cd),
    .credits_valid_o     (cv),
    .err_count_o         (err)
  );

  // Reflected form: LSB-first shift register with reversed poly 0xD008;
  // its complement is already in wire bit order.
  function automatic logic [15:0] crc_model(input logic [31:0] body);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = r[0] ^ body[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'hD008;
    end
    return ~r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_dllp(input logic [31:0] body, input logic [15:0] crc, input int gap);
    beat(body, 4'hF, 1'b0);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    beat({16'h0, crc}, 4'h3, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: an observable event is a credits_valid pulse or a change of flags/err count.
  initial begin
    logic  p_fc1, p_fc2;
    logic [7:0] p_err;
    snap_t e;
    p_fc1 = 1'b0;
    p_fc2 = 1'b0;
    p_err = 8'h0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cv || fc1 !== p_fc1 || fc2 !== p_fc2 || err !== p_err) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: cv=%0b fc1=%0b fc2=%0b err=%0d with empty queue at %0t",
                     cv, fc1, fc2, err, $time);
          end else begin
            e = q.pop_front();
            chk("p_hdr",    32'(ph),  32'(e.ph));
            chk("p_data",   32'(pd),  32'(e.pd));
            chk("np_hdr",   32'(nph), 32'(e.nph));
            chk("np_data",  32'(npd), 32'(e.npd));
            chk("cpl_hdr",  32'(cph), 32'(e.cph));
            chk("cpl_data", 32'(cd),  32'(e.cd));
            chk("fc1_flag", 32'(fc1), 32'(e.fc1));
            chk("fc2_flag", 32'(fc2), 32'(e.fc2));
            chk("err_count", 32'(err), 32'(e.err));
          end
        end
        p_fc1 = fc1;
        p_fc2 = fc2;
        p_err = err;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    fc_en  = 1'b1;
    tdata  = 32'h0;
    tkeep  = 4'h0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 3'b101;
    exp_s  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tready", 32'(tready), 32'h0);
    chk("reset_fc1",    32'(fc1),    32'h0);
    chk("reset_fc2",    32'(fc2),    32'h0);
    chk("reset_cv",     32'(cv),     32'h0);
    chk("reset_err",    32'(err),    32'h0);
    chk("reset_p_hdr",  32'(ph),     32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_reset", 32'(tready), 32'h1);
    mon_en = 1'b1;

    // UpdateFC-P and an Ack during INIT_FC1, with tvalid gaps: no event
    send_dllp(32'h12345680, crc_model(32'h12345680), 3);
    send_dllp(32'h00000000, crc_model(32'h00000000), 1);
    idle(3);
    chk("fc1_after_updatefc", 32'(fc1), 32'h0);
    chk("err_after_updatefc", 32'(err), 32'h0);

    // InitFC1-P: HdrFC 0xFF, DataFC 0x8FF
    exp_s.ph = 8'hFF;
    exp_s.pd = 12'h8FF;
    q.push_back(exp_s);
    send_dllp(32'hFFC83F40, crc_model(32'hFFC83F40), 0);

    // InitFC1-NP with CRC LSB flipped
    exp_s.err = 8'd1;
    q.push_back(exp_s);
    send_dllp(32'h20000450, crc_model(32'h20000450) ^ 16'h0001, 2);

    // Correct InitFC1-NP: HdrFC 0x10, DataFC 0x020
    exp_s.nph = 8'h10;
    exp_s.npd = 12'h020;
    q.push_back(exp_s);
    send_dllp(32'h20000450, crc_model(32'h20000450), 0);

    // tlast on the body beat
    exp_s.err = 8'd2;
    q.push_back(exp_s);
    beat(32'h20000460, 4'hF, 1'b1);

    // Three-beat DLLP: error on beat 2, beat 3 dropped
    exp_s.err = 8'd3;
    q.push_back(exp_s);
    beat(32'h20000460, 4'hF, 1'b0);
    beat({16'h0, crc_model(32'h20000460)}, 4'h3, 1'b0);
    beat(32'hDEADBEEF, 4'hF, 1'b1);

    // Good CRC but tkeep[1] low on the CRC beat
    exp_s.err = 8'd4;
    q.push_back(exp_s);
    beat(32'h20000460, 4'hF, 1'b0);
    beat({16'h0, crc_model(32'h20000460)}, 4'h1, 1'b1);

    // InitFC1-Cpl completes FC1
    exp_s.cph = 8'h10;
    exp_s.cd  = 12'h020;
    exp_s.fc1 = 1'b1;
    q.push_back(exp_s);
    send_dllp(32'h20000460, crc_model(32'h20000460), 1);

    // InitFC1-P repeat in INIT_FC2 must not touch credits
    send_dllp(32'h21430140, crc_model(32'h21430140), 0);
    idle(2);

    // InitFC2-P on VC1 bits: completes FC2, credits unchanged
    exp_s.fc2 = 1'b1;
    q.push_back(exp_s);
    send_dllp(32'h55AA33C1, crc_model(32'h55AA33C1), 2);

    // UpdateFC-NP in INIT_DONE is not latched
    send_dllp(32'h12345690, crc_model(32'h12345690), 0);
    idle(2);

    // One-cycle drop of fc_init_en clears flags, keeps credits
    exp_s.fc1 = 1'b0;
    exp_s.fc2 = 1'b0;
    q.push_back(exp_s);
    fc_en = 1'b0;
    @(posedge clk);
    #1;
    fc_en = 1'b1;
    idle(2);

    // Back in INIT_FC1: repeated InitFC1-P, latest value wins
    exp_s.ph = 8'h05;
    exp_s.pd = 12'h321;
    q.push_back(exp_s);
    send_dllp(32'h21430140, crc_model(32'h21430140), 0);
    exp_s.ph = 8'hFF;
    exp_s.pd = 12'h8FF;
    q.push_back(exp_s);
    send_dllp(32'hFFC83F40, crc_model(32'hFFC83F40), 0);

    // Drive the error counter to saturation, then past it
    while (exp_s.err != 8'hFF) begin
      exp_s.err = exp_s.err + 8'd1;
      q.push_back(exp_s);
      beat(32'h0, 4'hF, 1'b1);
    end
    repeat (3) beat(32'h0, 4'hF, 1'b1);
    idle(10);
    chk("err_saturated", 32'(err), 32'hFF);
    chk("fc1_final",     32'(fc1), 32'h0);
    chk("pending_events", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
